uart_bus_bridge: RTL and testbench

// UART-to-bus bridge: the initiator side of the peripheral bus. Receives 8N1 command frames on a serial pin
// and issues single-cycle rd/wr strobes on the 32-bit peripheral bus (TH/TL/TCON/led/digi/UART regs @0x4000_00xx).

---
 rtl/uart_bus_bridge.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// UART-to-bus bridge: decodes 8N1 'W'/'R' command frames into single-cycle peripheral
// bus strobes and returns ACK, NAK or read data over the serial TX pin.
module uart_bus_bridge #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int TIMEOUT_CLKS = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
    localparam logic [2:0] C_IDLE = 3'd0, C_ADDR = 3'd1, C_DATA = 3'd2, C_EXEC = 3'd3, C_RESP = 3'd4;

    logic          rx_s1_q, rx_s2_q, rx_s3_q;
    logic [1:0]    rx_st_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;
    logic          rx_vld_q, rx_ferr_q;

    logic          tx_act_q, tx_q;
    logic [8:0]    tx_sh_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_bit_q;
    logic          tx_done, tx_load;
    logic [7:0]    tx_byte;

    logic [2:0]    st_q, st_d;
    logic          is_wr_q, is_wr_d;
    logic [1:0]    bcnt_q, bcnt_d, left_q, left_d;
    logic [31:0]   addr_sh_q, addr_sh_d, data_sh_q, data_sh_d, resp_q, resp_d;
    logic [31:0]   bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [TW-1:0] to_q, to_d;
    logic [31:0]   rd_addr;

    // Receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_s3_q   <= 1'b1;
            rx_st_q   <= RX_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_vld_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else begin
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_s3_q   <= rx_s2_q;
            rx_vld_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
            case (rx_st_q)
                RX_IDLE: begin
                    if (rx_s3_q && !rx_s2_q) begin
                        rx_st_q  <= RX_START;
                        rx_cnt_q <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q  <= '0;
                        rx_st_q   <= RX_IDLE;
                        rx_vld_q  <= rx_s2_q;
                        rx_ferr_q <= !rx_s2_q;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign rd_addr = {addr_sh_q[23:0], rx_sh_q};

    always_comb begin
        st_d        = st_q;
        is_wr_d     = is_wr_q;
        bcnt_d      = bcnt_q;
        left_d      = left_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        resp_d      = resp_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        to_d        = to_q;
        tx_load     = 1'b0;
        tx_byte     = 8'h00;
        case (st_q)
            C_IDLE: begin
                to_d = '0;
                if (rx_vld_q) begin
                    if (rx_sh_q == 8'h57 || rx_sh_q == 8'h52) begin
                        is_wr_d = (rx_sh_q == 8'h57);
                        bcnt_d  = '0;
                        st_d    = C_ADDR;
                    end else begin
                        tx_load = 1'b1;
                        tx_byte = 8'h15;
                        left_d  = '0;
                        st_d    = C_RESP;
                    end
                end
            end
            C_ADDR, C_DATA: begin
                if (rx_ferr_q) begin
                    st_d = C_IDLE;
                end else if (rx_vld_q) begin
                    to_d   = '0;
                    bcnt_d = bcnt_q + 1'b1;
                    if (st_q == C_ADDR) begin
                        addr_sh_d = rd_addr;
                        if (bcnt_q == 2'd3) begin
                            st_d = is_wr_q ? C_DATA : C_EXEC;
                            if (!is_wr_q && rd_addr[1:0] == 2'b00) bus_addr_d = rd_addr;
                        end
                    end else begin
                        data_sh_d = {data_sh_q[23:0], rx_sh_q};
                        if (bcnt_q == 2'd3) begin
                            st_d = C_EXEC;
                            if (addr_sh_q[1:0] == 2'b00) begin
                                bus_addr_d  = addr_sh_q;
                                bus_wdata_d = {data_sh_q[23:0], rx_sh_q};
                            end
                        end
                    end
                end else if (to_q == TO_LAST) begin
                    st_d = C_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            C_EXEC: begin
                // First reply byte launches here so its start bit follows this cycle directly
                st_d    = C_RESP;
                tx_load = 1'b1;
                left_d  = '0;
                if (addr_sh_q[1:0] != 2'b00) begin
                    tx_byte = 8'h15;
                end else if (is_wr_q) begin
                    tx_byte = 8'h06;
                end else begin
                    tx_byte = bus_rdata[31:24];
                    resp_d  = {bus_rdata[23:0], 8'h00};
                    left_d  = 2'd3;
                end
            end
            default: begin
                if (tx_done) begin
                    if (left_q != 2'd0) begin
                        tx_load = 1'b1;
                        tx_byte = resp_q[31:24];
                        resp_d  = {resp_q[23:0], 8'h00};
                        left_d  = left_q - 1'b1;
                    end else begin
                        st_d = C_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q        <= C_IDLE;
            is_wr_q     <= 1'b0;
            bcnt_q      <= '0;
            left_q      <= '0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            resp_q      <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            to_q        <= '0;
        end else begin
            st_q        <= st_d;
            is_wr_q     <= is_wr_d;
            bcnt_q      <= bcnt_d;
            left_q      <= left_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            resp_q      <= resp_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            to_q        <= to_d;
        end
    end

    // Transmitter: tx_bit_q is the bit on the line (0 start, 1-8 data, 9 stop)
    assign tx_done = tx_act_q && (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_act_q <= 1'b0;
            tx_q     <= 1'b1;
            tx_sh_q  <= '0;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
        end else if (tx_load) begin
            tx_act_q <= 1'b1;
            tx_q     <= 1'b0;
            tx_sh_q  <= {1'b1, tx_byte};
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
        end else if (tx_act_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_act_q <= 1'b0;
                    tx_q     <= 1'b1;
                end else begin
                    tx_q     <= tx_sh_q[0];
                    tx_sh_q  <= {1'b0, tx_sh_q[8:1]};
                    tx_bit_q <= tx_bit_q + 1'b1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    assign uart_tx   = tx_q;
    assign bus_wr    = (st_q == C_EXEC) && is_wr_q && (addr_sh_q[1:0] == 2'b00);
    assign bus_rd    = (st_q == C_EXEC) && !is_wr_q && (addr_sh_q[1:0] == 2'b00);
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign busy      = (st_q != C_IDLE);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: directed command frames, a command-level reference model
// and a per-cycle compare process that also decodes the serial reply.
module tb_uart_bus_bridge;
    localparam int CPB = 8;
    localparam int TO  = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        uart_rx = 1'b1;
    logic        uart_tx, bus_rd, bus_wr, busy;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] rdata_v = 32'h0;

    uart_bus_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(rdata_v), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } strb_t;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    strb_t       exp_strb[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  cmd_q[$];
    int          n_wr = 0;
    int          n_rd = 0;
    logic [7:0]  last_tx = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event not expected / not seen", name);
    endtask

    // Compare process: bus strobes against the model, serial reply decoded and matched
    initial begin : compare
        strb_t       s;
        bit          mon_act = 0;
        bit          lat_pend = 0;
        bit          mid_resp = 0;
        int          mon_t = 0;
        int          k;
        int unsigned strobe_cyc = 0;
        int unsigned prev_start = 0;
        logic [7:0]  mon_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_act  = 0;
                mid_resp = 0;
                lat_pend = 0;
            end else begin
                if (bus_rd || bus_wr) begin
                    strobe_cyc = cyc;
                    lat_pend   = 1;
                    if (bus_wr) n_wr++; else n_rd++;
                    check("rd_wr_exclusive", {31'b0, bus_rd & bus_wr}, 32'h0);
                    if (exp_strb.size() == 0) begin
                        fail_now("unexpected_strobe");
                    end else begin
                        s = exp_strb.pop_front();
                        check("strobe_kind", {31'b0, bus_wr}, {31'b0, s.is_wr});
                        check("bus_addr", bus_addr, s.addr);
                        if (s.is_wr) check("bus_wdata", bus_wdata, s.wdata);
                    end
                end
                if (!mon_act) begin
                    if (uart_tx === 1'b0) begin
                        mon_act = 1;
                        mon_t   = 0;
                        if (lat_pend) begin
                            check("tx_start_latency", cyc, strobe_cyc + 1);
                            lat_pend = 0;
                        end
                        if (mid_resp) check("tx_back_to_back", cyc - prev_start, 32'd80);
                        prev_start = cyc;
                    end
                end else begin
                    mon_t++;
                    if (mon_t % CPB == CPB / 2) begin
                        k = mon_t / CPB;
                        if (k >= 1 && k <= 8) begin
                            mon_byte[k-1] = uart_tx;
                        end else if (k == 9) begin
                            mon_act = 0;
                            check("tx_stop_bit", {31'b0, uart_tx}, 32'h1);
                            last_tx = mon_byte;
                            if (exp_tx.size() == 0) fail_now("unexpected_tx_byte");
                            else check("tx_byte", {24'b0, mon_byte}, {24'b0, exp_tx.pop_front()});
                            mid_resp = (exp_tx.size() != 0);
                        end
                    end
                end
            end
        end
    end

    // Command-level model: what the bridge must do for the bytes in cmd_q
    task automatic model_cmd();
        logic [31:0] a, d;
        strb_t       s;
        if (cmd_q[0] != 8'h57 && cmd_q[0] != 8'h52) begin
            exp_tx.push_back(8'h15);
            return;
        end
        a = {cmd_q[1], cmd_q[2], cmd_q[3], cmd_q[4]};
        if (a % 4 != 0) begin
            exp_tx.push_back(8'h15);
        end else if (cmd_q[0] == 8'h57) begin
            d = {cmd_q[5], cmd_q[6], cmd_q[7], cmd_q[8]};
            s.is_wr = 1; s.addr = a; s.wdata = d;
            exp_strb.push_back(s);
            exp_tx.push_back(8'h06);
        end else begin
            s.is_wr = 0; s.addr = a; s.wdata = 32'h0;
            exp_strb.push_back(s);
            for (int i = 3; i >= 0; i--) exp_tx.push_back(rdata_v[8*i +: 8]);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_clks(CPB);
        end
        uart_rx = stop;
        wait_clks(CPB);
        uart_rx = 1'b1;
    endtask

    task automatic send_cmd();
        foreach (cmd_q[i]) begin
            send_byte(cmd_q[i], 1'b1);
            if (i == 0) begin
                wait_clks(2);
                check("busy_after_opcode", {31'b0, busy}, 32'h1);
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1500 && (exp_tx.size() != 0 || exp_strb.size() != 0); i++) wait_clks(1);
        if (exp_tx.size() != 0 || exp_strb.size() != 0) fail_now("response_timeout");
        exp_tx.delete();
        exp_strb.delete();
        wait_clks(10);
        check("busy_done", {31'b0, busy}, 32'h0);
        check("tx_idle", {31'b0, uart_tx}, 32'h1);
    endtask

    task automatic do_cmd();
        model_cmd();
        send_cmd();
        wait_drain();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        wait_clks(3);
        check("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
        check("rst_bus_rd", {31'b0, bus_rd}, 32'h0);
        check("rst_bus_wr", {31'b0, bus_wr}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        reset = 1'b1;
        wait_clks(5);

        // Write
        cmd_q = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'hA5};
        do_cmd();
        check("t1_n_wr", n_wr, 32'd1);
        check("t1_addr_hold", bus_addr, 32'h4000000C);
        check("t1_wdata_hold", bus_wdata, 32'h000000A5);
        check("t1_ack", {24'b0, last_tx}, 32'h06);

        // Read
        rdata_v = 32'h0000003C;
        cmd_q = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h10};
        do_cmd();
        check("t2_n_rd", n_rd, 32'd1);
        check("t2_addr", bus_addr, 32'h40000010);
        check("t2_wdata_kept", bus_wdata, 32'h000000A5);
        check("t2_last_byte", {24'b0, last_tx}, 32'h3C);

        // Bad opcode and misaligned read
        cmd_q = '{8'h41};
        do_cmd();
        check("t3_nak", {24'b0, last_tx}, 32'h15);
        cmd_q = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h02};
        do_cmd();
        check("t3_misalign_nak", {24'b0, last_tx}, 32'h15);
        check("t3_no_strobe", n_wr + n_rd, 32'd2);
        check("t3_addr_kept", bus_addr, 32'h40000010);

        // Glitch and framing error
        uart_rx = 1'b0;
        wait_clks(2);
        uart_rx = 1'b1;
        wait_clks(100);
        check("t4_glitch_idle", {31'b0, busy}, 32'h0);
        send_byte(8'h57, 1'b1);
        send_byte(8'h40, 1'b1);
        check("t4_busy_mid_cmd", {31'b0, busy}, 32'h1);
        send_byte(8'h00, 1'b0);
        wait_clks(20);
        check("t4_ferr_idle", {31'b0, busy}, 32'h0);
        wait_clks(300);
        check("t4_no_strobe", n_wr + n_rd, 32'd2);

        // Timeout then a normal read
        send_byte(8'h57, 1'b1);
        send_byte(8'h40, 1'b1);
        wait_clks(250);
        check("t5_timeout_idle", {31'b0, busy}, 32'h0);
        check("t5_no_strobe", n_wr + n_rd, 32'd2);
        rdata_v = 32'hDEADBEEF;
        cmd_q = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h20};
        do_cmd();
        check("t5_n_rd", n_rd, 32'd2);
        check("t5_last_byte", {24'b0, last_tx}, 32'hEF);

        // Reset during second reply byte
        rdata_v = 32'h11223344;
        cmd_q = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h14};
        model_cmd();
        send_cmd();
        for (int i = 0; i < 400 && exp_tx.size() > 3; i++) wait_clks(1);
        check("t6_first_byte_seen", exp_tx.size(), 32'd3);
        wait_clks(30);
        reset = 1'b0;
        #1;
        check("t6_rst_tx", {31'b0, uart_tx}, 32'h1);
        check("t6_rst_busy", {31'b0, busy}, 32'h0);
        exp_tx.delete();
        exp_strb.delete();
        wait_clks(3);
        reset = 1'b1;
        wait_clks(5);
        cmd_q = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h5A};
        do_cmd();
        check("t6_n_wr", n_wr, 32'd2);
        check("t6_wdata", bus_wdata, 32'h0000005A);
        check("t6_ack", {24'b0, last_tx}, 32'h06);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
